// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding, chunk sizing
// and the saturation limits used when ADDSUB_PIPE_SAT_EN is defined.
`timescale 1ns/1ps
package addsub_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  // Bit patterns of the signed limits, valid in the low `width` bits (width <= 64).
  function automatic logic [63:0] SAT_MAX(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] SAT_MIN(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: resolves chunk IDX of the sum with the incoming carry and
// forwards the operands, partial sum and per-beat flags to the next stage.
`timescale 1ns/1ps
module addsub_stage #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int IDX      = 0,
  parameter bit RST_DATA = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             sub_o
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] sum_nxt;

  always_comb begin
    chunk_add = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_i};
    sum_nxt   = sum_i;
    sum_nxt[LO +: CHUNK] = chunk_add[CHUNK-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_o <= 1'b0;
    end else if (en) begin
      vld_o <= vld_i;
    end
  end

  // Data only loads for real beats, so bubbles (and X on idle inputs) never reach it;
  // only the output-facing stage clears its data on reset.
  always_ff @(posedge clock) begin
    if (RST_DATA && reset) begin
      a_o   <= '0;
      b_o   <= '0;
      sum_o <= '0;
      c_o   <= 1'b0;
      sub_o <= 1'b0;
    end else if (en && vld_i) begin
      a_o   <= a_i;
      b_o   <= b_i;
      sum_o <= sum_nxt;
      c_o   <= chunk_add[CHUNK];
      sub_o <= sub_i;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, one CHUNK per stage, valid/ready on both
// sides. Define ADDSUB_PIPE_SAT_EN to saturate out_sum on signed overflow.
`timescale 1ns/1ps
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  generate
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("addsub_pipe: WIDTH must be a positive multiple of STAGES");
    end
  endgenerate

  logic             vld_p [STAGES+1];
  logic [WIDTH-1:0] a_p   [STAGES+1];
  logic [WIDTH-1:0] b_p   [STAGES+1];
  logic [WIDTH-1:0] sum_p [STAGES+1];
  logic             c_p   [STAGES+1];
  logic             sub_p [STAGES+1];

  logic adv;
  logic a_msb, b_msb, s_msb;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage 0 inputs: subtract is A + ~B + 1
  assign vld_p[0] = in_valid;
  assign a_p[0]   = in_a;
  assign b_p[0]   = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign sum_p[0] = '0;
  assign c_p[0]   = (in_sub == OP_ADD) ? in_c : 1'b1;
  assign sub_p[0] = in_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH   (WIDTH),
      .CHUNK   (CHUNK),
      .IDX     (k),
      .RST_DATA(k == STAGES - 1)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .vld_i (vld_p[k]),
      .a_i   (a_p[k]),
      .b_i   (b_p[k]),
      .sum_i (sum_p[k]),
      .c_i   (c_p[k]),
      .sub_i (sub_p[k]),
      .vld_o (vld_p[k+1]),
      .a_o   (a_p[k+1]),
      .b_o   (b_p[k+1]),
      .sum_o (sum_p[k+1]),
      .c_o   (c_p[k+1]),
      .sub_o (sub_p[k+1])
    );
  end

  // Output stage
  assign a_msb     = a_p[STAGES][WIDTH-1];
  assign b_msb     = b_p[STAGES][WIDTH-1];
  assign s_msb     = sum_p[STAGES][WIDTH-1];
  assign out_valid = vld_p[STAGES];
  assign out_c     = c_p[STAGES];
  assign out_ovf   = (a_msb == b_msb) & (s_msb != a_msb);

`ifdef ADDSUB_PIPE_SAT_EN
  localparam logic [63:0] SMAX64 = SAT_MAX(WIDTH);
  localparam logic [63:0] SMIN64 = SAT_MIN(WIDTH);
  localparam logic signed [WIDTH-1:0] SMAX = SMAX64[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] SMIN = SMIN64[WIDTH-1:0];

  // Overflow direction follows the sign of A: positive A can only overflow upwards.
  function automatic logic signed [WIDTH-1:0] sat_sum(input logic signed [WIDTH-1:0] raw,
                                                      input logic ovf, input logic a_neg);
    if (!ovf) return raw;
    return a_neg ? SMIN : SMAX;
  endfunction

  assign out_sum = sat_sum(sum_p[STAGES], out_ovf, a_msb);
`else
  assign out_sum = sum_p[STAGES];
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, STAGES=4); honours ADDSUB_PIPE_SAT_EN.
`timescale 1ns/1ps
module tb_addsub_pipe;

  localparam int W = 16;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_c;
  logic         out_ovf;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_c    (out_c),
    .out_ovf  (out_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    int           acc;
    logic         has_k;
    logic [W-1:0] ks;
    logic         kc;
    logic         kovf;
  } beat_t;

  beat_t        q[$];
  int           n_checks = 0;
  int           n_err    = 0;
  int           adv_cnt  = 0;
  logic [W-1:0] held;
  bit           held_ok  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: true integer result, then wrap / saturate.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic sub, output logic [W-1:0] sum, output logic co,
                       output logic ovf);
    longint ua, ub, sa, sb, r, rs;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r  = ua - ub;
      co = (ua >= ub);
      rs = sa - sb;
    end else begin
      r  = ua + ub + longint'(c);
      co = (r > 65535);
      rs = sa + sb + longint'(c);
    end
    ovf = (rs > 32767) || (rs < -32768);
    sum = r[W-1:0];
`ifdef ADDSUB_PIPE_SAT_EN
    if (ovf) sum = (rs > 0) ? 16'h7FFF : 16'h8000;
`endif
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic sub, input logic ordy, input logic rs,
                      input logic has_k, input logic [W-1:0] ks, input logic kc,
                      input logic kovf);
    bit           exp_v, adv;
    logic [W-1:0] m_sum;
    logic         m_c, m_ovf;
    beat_t        bt;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_c      = c;
    in_sub    = sub;
    out_ready = ordy;
    reset     = rs;
    #1;
    if (rs) begin
      q.delete();
      held_ok = 0;
    end else begin
      exp_v = (q.size() > 0) && (adv_cnt - q[0].acc == S);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("in_ready", 32'(in_ready), 32'(!(exp_v && !ordy)));
      check("no_x", 32'($isunknown({out_sum, out_c, out_ovf})), 32'd0);
      if (exp_v) begin
        model(q[0].a, q[0].b, q[0].c, q[0].sub, m_sum, m_c, m_ovf);
        check("sum", 32'(out_sum), 32'(m_sum));
        check("carry", 32'(out_c), 32'(m_c));
        check("ovf", 32'(out_ovf), 32'(m_ovf));
        if (q[0].has_k) begin
          check("k_sum", 32'(out_sum), 32'(q[0].ks));
          check("k_carry", 32'(out_c), 32'(q[0].kc));
          check("k_ovf", 32'(out_ovf), 32'(q[0].kovf));
        end
        if (held_ok) check("hold_sum", 32'(out_sum), 32'(held));
      end
      held_ok = exp_v && !ordy;
      held    = out_sum;
      adv     = !exp_v || ordy;
      if (exp_v && ordy) void'(q.pop_front());
      if (v && adv) begin
        bt = '{a: a, b: b, c: c, sub: sub, acc: adv_cnt, has_k: has_k, ks: ks, kc: kc,
               kovf: kovf};
        q.push_back(bt);
      end
      if (adv) adv_cnt++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() > 0; i++) idle(1'b1);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic send_k(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, input logic [W-1:0] ks, input logic kc,
                        input logic kovf);
    step(1'b1, a, b, c, sub, 1'b1, 1'b0, 1'b1, ks, kc, kovf);
    drain();
  endtask

  task automatic send_rand(input logic ordy);
    step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy, 1'b0,
         1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sum"}, 32'(out_sum), 32'd0);
    check({tag, "_c"}, 32'(out_c), 32'd0);
    check({tag, "_ovf"}, 32'(out_ovf), 32'd0);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    @(negedge clock);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_zero_out("rst");

    // Directed corner cases
    send_k(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_k(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef ADDSUB_PIPE_SAT_EN
    send_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
    send_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
    send_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    send_k(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);

    // Streaming: 8 back-to-back beats
    for (int i = 0; i < 8; i++) send_rand(1'b1);
    drain();

    // Backpressure for 3 cycles mid-stream
    for (int i = 0; i < 12; i++) send_rand(!(i >= 5 && i < 8));
    drain();

    // Idle inputs carrying X must not disturb outputs
    for (int i = 0; i < 3; i++)
      step(1'b0, 'x, 'x, 1'bx, 1'bx, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Random traffic with random backpressure
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) send_rand($urandom_range(0, 3) != 0);
      else idle($urandom_range(0, 1) == 1);
    end
    drain();

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_zero_out("midrst");
    for (int i = 0; i < 8; i++) idle(1'b1);
    send_k(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
